// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - command FIFO and write sequencer feeding the 256x256 RGB framebuffer
//
// Purpose: buffers pixel commands from game logic and turns each one into
// single-cycle framebuffer write strobes: PLOT (one pixel), ROW (all 256
// pixels of one line) or FILL (all 65536 pixels). iHOLD stalls the write
// sequencer without losing or repeating a pixel; the FIFO keeps accepting.
//
// Ports:
//   iCLK, iRST_N            clock, asynchronous active-low reset
//   iCMD_VALID, oCMD_READY  command handshake (ready = FIFO not full, registered)
//   iCMD_OP                 00 PLOT, 01 ROW, 10 FILL, 11 NOP
//   iCMD_X, iCMD_Y          pixel coordinates (x ignored by ROW, both by FILL)
//   iCMD_RGB                {R,G,B}, R in the MSBs
//   iHOLD                   freeze the sequencer (framebuffer port busy)
//   oFB_WE, oFB_ADDR        registered write strobe and address {x,y}
//   oFB_R, oFB_G, oFB_B     registered write data
//   oBUSY                   commands queued or sequencer not idle
//   oDONE                   one-cycle pulse alongside the last write of ROW/FILL

module fb_pixel_writer #(
   parameter int FIFO_DEPTH = 4,
   parameter int CW         = 12
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   input  logic            iCMD_VALID,
   output logic            oCMD_READY,
   input  logic [1:0]      iCMD_OP,
   input  logic [7:0]      iCMD_X,
   input  logic [7:0]      iCMD_Y,
   input  logic [3*CW-1:0] iCMD_RGB,
   input  logic            iHOLD,
   output logic            oFB_WE,
   output logic [15:0]     oFB_ADDR,
   output logic [CW-1:0]   oFB_R,
   output logic [CW-1:0]   oFB_G,
   output logic [CW-1:0]   oFB_B,
   output logic            oBUSY,
   output logic            oDONE
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = 2 + 8 + 8 + 3*CW;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_PLOT, S_ROW, S_FILL} state_t;

   state_t state_q;

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW:0]   count_q;
   logic [PW:0]   count_d;
   logic          ready_q;
   logic          push;
   logic          pop;
   logic          empty;

   logic [EW-1:0]   head;
   logic [1:0]      h_op;
   logic [7:0]      h_x;
   logic [7:0]      h_y;
   logic [3*CW-1:0] h_rgb;

   assign empty = (count_q == '0);
   assign push  = iCMD_VALID & ready_q;
   // Popping is the IDLE-state dispatch; it must match the FSM's IDLE branch.
   assign pop   = (state_q == S_IDLE) & ~empty & ~iHOLD;

   assign head  = mem_q[rd_ptr_q];
   assign h_op  = head[EW-1 -: 2];
   assign h_x   = head[3*CW+15 -: 8];
   assign h_y   = head[3*CW+7 -: 8];
   assign h_rgb = head[3*CW-1:0];

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         // Ready comes from the next count so it drops the edge the FIFO fills.
         ready_q <= (count_d != FULL_CNT);
      end
   end

   always_ff @(posedge iCLK) begin
      if (push) mem_q[wr_ptr_q] <= {iCMD_OP, iCMD_X, iCMD_Y, iCMD_RGB};
   end

   // ------------------------------------------------------------------
   // Write sequencer
   // cnt_q holds the next sweep index still to be written; the index shown
   // on oFB_ADDR has already been issued. A held edge therefore never
   // re-issues or skips an index. last_q marks that the all-ones index has
   // been issued, so the following unheld edge returns to IDLE.
   // ------------------------------------------------------------------
   logic [15:0]     cnt_q;
   logic            last_q;
   logic [7:0]      y_q;
   logic            we_q;
   logic            done_q;
   logic [15:0]     addr_q;
   logic [3*CW-1:0] data_q;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         y_q     <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         if (!iHOLD) begin
            case (state_q)
               S_IDLE: begin
                  if (!empty) begin
                     y_q    <= h_y;
                     data_q <= h_rgb;
                     last_q <= 1'b0;
                     cnt_q  <= 16'd1;
                     case (h_op)
                        2'b00: begin
                           state_q <= S_PLOT;
                           we_q    <= 1'b1;
                           addr_q  <= {h_x, h_y};
                        end
                        2'b01: begin
                           state_q <= S_ROW;
                           we_q    <= 1'b1;
                           addr_q  <= {8'h00, h_y};
                        end
                        2'b10: begin
                           state_q <= S_FILL;
                           we_q    <= 1'b1;
                           addr_q  <= 16'h0000;
                        end
                        default: state_q <= S_IDLE;
                     endcase
                  end
               end
               S_PLOT: state_q <= S_IDLE;
               S_ROW: begin
                  if (last_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     // Row sweep uses only the low byte of the counter.
                     we_q   <= 1'b1;
                     addr_q <= {cnt_q[7:0], y_q};
                     done_q <= (cnt_q[7:0] == 8'hFF);
                     last_q <= (cnt_q[7:0] == 8'hFF);
                     cnt_q  <= {8'h00, cnt_q[7:0] + 8'd1};
                  end
               end
               S_FILL: begin
                  if (last_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     we_q   <= 1'b1;
                     addr_q <= cnt_q;
                     done_q <= (cnt_q == 16'hFFFF);
                     last_q <= (cnt_q == 16'hFFFF);
                     cnt_q  <= cnt_q + 16'd1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign oCMD_READY = ready_q;
   assign oFB_WE     = we_q;
   assign oFB_ADDR   = addr_q;
   assign oFB_R      = data_q[3*CW-1 -: CW];
   assign oFB_G      = data_q[2*CW-1 -: CW];
   assign oFB_B      = data_q[CW-1:0];
   assign oDONE      = done_q;
   assign oBUSY      = ~empty | (state_q != S_IDLE);

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb/tb_fb_pixel_writer.sv - self-checking bench for fb_pixel_writer

module tb_fb_pixel_writer;

   localparam int CW = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [7:0]    cmd_x = '0;
   logic [7:0]    cmd_y = '0;
   logic [35:0]   cmd_rgb = '0;
   logic          hold = 1'b0;
   logic          fb_we;
   logic [15:0]   fb_addr;
   logic [CW-1:0] fb_r;
   logic [CW-1:0] fb_g;
   logic [CW-1:0] fb_b;
   logic          busy;
   logic          done;

   fb_pixel_writer #(.FIFO_DEPTH(4), .CW(CW)) dut (
      .iCLK       (clk),
      .iRST_N     (rst_n),
      .iCMD_VALID (cmd_valid),
      .oCMD_READY (cmd_ready),
      .iCMD_OP    (cmd_op),
      .iCMD_X     (cmd_x),
      .iCMD_Y     (cmd_y),
      .iCMD_RGB   (cmd_rgb),
      .iHOLD      (hold),
      .oFB_WE     (fb_we),
      .oFB_ADDR   (fb_addr),
      .oFB_R      (fb_r),
      .oFB_G      (fb_g),
      .oFB_B      (fb_b),
      .oBUSY      (busy),
      .oDONE      (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] addr;
      logic [35:0] rgb;
      logic        done;
   } wr_t;

   wr_t exp_q[$];
   wr_t e;
   int  n_cmp = 0;
   int  n_err = 0;
   int  n_we  = 0;

   logic hold_req  = 1'b0;
   logic rand_hold = 1'b0;
   logic hold_s    = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Expected write stream of one accepted command, straight from the op rules.
   task automatic model_cmd(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                            input logic [35:0] rgb);
      case (op)
         2'b00: exp_q.push_back('{addr: {x, y}, rgb: rgb, done: 1'b0});
         2'b01: for (int c = 0; c < 256; c++)
                   exp_q.push_back('{addr: {8'(c), y}, rgb: rgb, done: (c == 255)});
         2'b10: for (int a = 0; a < 65536; a++)
                   exp_q.push_back('{addr: 16'(a), rgb: rgb, done: (a == 65535)});
         default: ;
      endcase
   endtask

   // Hold is changed 2 time units after the edge; the DUT samples it at the next edge.
   always @(posedge clk) begin
      hold_s = hold;
      #2;
      hold = rand_hold ? ($urandom_range(0, 5) == 0) : hold_req;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_s) chk("we_during_hold", 64'(fb_we), 64'd0);
         if (exp_q.size() != 0) chk("busy_while_pending", 64'(busy), 64'd1);
         if (fb_we) begin
            n_we++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_write: got addr %h with no write pending, required none", fb_addr);
            end else begin
               e = exp_q.pop_front();
               if ({fb_addr, fb_r, fb_g, fb_b, done} !== {e.addr, e.rgb, e.done}) begin
                  n_err++;
                  $display("FAIL write_stream: got addr=%h rgb=%h%h%h done=%b, required addr=%h rgb=%h done=%b",
                           fb_addr, fb_r, fb_g, fb_b, done, e.addr, e.rgb, e.done);
               end
            end
         end else begin
            chk("done_without_write", 64'(done), 64'd0);
         end
      end
   end

   // Call and return just after a rising edge; the push is accepted on an edge where ready was high.
   task automatic push_cmd(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                           input logic [35:0] rgb);
      logic r;
      bit   ok;
      int   waited;
      ok = 0;
      waited = 0;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_x = x;
      cmd_y = y;
      cmd_rgb = rgb;
      while (!ok && waited < 2000) begin
         @(negedge clk);
         r = cmd_ready;
         @(posedge clk);
         if (r) begin
            ok = 1;
            model_cmd(op, x, y, rgb);
         end
         waited++;
         #1;
      end
      cmd_valid = 1'b0;
      if (!ok) chk("push_timeout", 64'(ok), 64'd1);
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) ok = 1;
      end
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL idle_timeout: got %0d writes pending, required 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   int   nwe;
   int   nlow;
   int   done_at;
   int   hcnt;
   int   n0;
   int   r;
   bit   started;
   bit   fin;
   bit   armed;
   bit   found;
   logic [1:0] op;

   initial begin
      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 64'(cmd_ready), 64'd0);
      chk("reset_outputs", {fb_we, fb_addr, fb_r, fb_g, fb_b, busy, done}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_before_first_clock", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("ready_after_first_clock", 64'(cmd_ready), 64'd1);
      @(posedge clk);
      #1;

      // ---------------- single PLOT, latency ----------------
      push_cmd(2'b00, 8'd200, 8'd100, 36'hFFF_FFF_FFF);
      chk("model_plot_addr", 64'(exp_q[0].addr), 64'hC864);
      @(negedge clk);
      chk("plot_we_after_push_edge", 64'(fb_we), 64'd0);
      @(negedge clk);
      chk("plot_we_after_pop_edge", 64'(fb_we), 64'd1);
      chk("plot_addr", 64'(fb_addr), 64'hC864);
      chk("plot_rgb", {fb_r, fb_g, fb_b}, 64'hFFF_FFF_FFF);
      @(negedge clk);
      chk("plot_single_cycle", 64'(fb_we), 64'd0);
      @(posedge clk);
      #1;
      wait_idle(50);

      // ---------------- 5 PLOTs, FIFO full ----------------
      hold_req = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
         push_cmd(2'b00, 8'(10 + k), 8'(20 * k), 36'(k * 36'h111_111_111));
      @(negedge clk);
      chk("ready_low_when_full", 64'(cmd_ready), 64'd0);
      chk("busy_when_full", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      hold_req = 1'b0;
      push_cmd(2'b00, 8'hFF, 8'hFF, 36'hABC_DEF_123);
      wait_idle(100);

      // ---------------- ROW y=7 ----------------
      push_cmd(2'b01, 8'h55, 8'd7, 36'h00F_000_000);
      chk("model_row_first", 64'(exp_q[0].addr), 64'h0007);
      chk("model_row_last", {exp_q[255].addr, exp_q[255].done}, {16'hFF07, 1'b1});
      nwe = 0;
      done_at = 0;
      started = 0;
      fin = 0;
      for (int i = 0; i < 400 && !fin; i++) begin
         @(negedge clk);
         if (fb_we) begin
            started = 1;
            nwe++;
            if (done) done_at = nwe;
         end else if (started) begin
            fin = 1;
         end
      end
      chk("row_consecutive_writes", 64'(nwe), 64'd256);
      chk("row_done_on_last", 64'(done_at), 64'd256);
      @(posedge clk);
      #1;
      wait_idle(50);

      // ---------------- FILL with a 10-cycle hold at index 1000 ----------------
      push_cmd(2'b10, 8'h12, 8'h34, 36'h0);
      chk("model_fill_size", 64'(exp_q.size()), 64'd65536);
      chk("model_fill_last", {exp_q[65535].addr, exp_q[65535].done}, {16'hFFFF, 1'b1});
      nwe = 0;
      nlow = 0;
      hcnt = 0;
      armed = 1;
      started = 0;
      fin = 0;
      for (int i = 0; i < 70000 && !fin; i++) begin
         @(negedge clk);
         if (fb_we) begin
            started = 1;
            nwe++;
            if (done) fin = 1;
            if (armed && fb_addr == 16'd1000) begin
               armed = 0;
               hcnt = 10;
            end
         end else if (started) begin
            nlow++;
         end
         @(posedge clk);
         #1;
         if (hcnt > 0) begin
            hold_req = 1'b1;
            hcnt--;
         end else begin
            hold_req = 1'b0;
         end
      end
      hold_req = 1'b0;
      chk("fill_completed", 64'(fin), 64'd1);
      chk("fill_write_count", 64'(nwe), 64'd65536);
      chk("fill_hold_gap", 64'(nlow), 64'd10);
      wait_idle(50);

      // ---------------- NOP between two PLOTs ----------------
      n0 = n_we;
      push_cmd(2'b00, 8'($urandom), 8'($urandom), 36'({$urandom, $urandom}));
      push_cmd(2'b11, 8'($urandom), 8'($urandom), 36'({$urandom, $urandom}));
      push_cmd(2'b00, 8'($urandom), 8'($urandom), 36'({$urandom, $urandom}));
      wait_idle(50);
      chk("nop_write_count", 64'(n_we - n0), 64'd2);

      // ---------------- randomized mix with random hold ----------------
      rand_hold = 1'b1;
      for (int k = 0; k < 24; k++) begin
         r = $urandom_range(0, 9);
         op = (r < 6) ? 2'b00 : ((r < 8) ? 2'b01 : 2'b11);
         push_cmd(op, 8'($urandom), 8'($urandom), 36'({$urandom, $urandom}));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      @(posedge clk);
      #1;
      rand_hold = 1'b0;
      wait_idle(20000);

      // ---------------- reset in the middle of FILL ----------------
      push_cmd(2'b10, 8'h00, 8'h00, 36'h5A5_A5A_5A5);
      push_cmd(2'b00, 8'd1, 8'd2, 36'h123_456_789);
      push_cmd(2'b01, 8'd3, 8'd4, 36'h987_654_321);
      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(negedge clk);
         if (fb_we && fb_addr == 16'd300) found = 1;
      end
      chk("fill_reached_300", 64'(found), 64'd1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("async_reset_outputs", {fb_we, fb_addr, fb_r, fb_g, fb_b, busy, done}, 64'd0);
      chk("async_reset_ready", 64'(cmd_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n0 = n_we;
      @(negedge clk);
      chk("fifo_empty_after_reset", 64'(busy), 64'd0);
      repeat (20) @(negedge clk);
      chk("no_writes_after_reset", 64'(n_we - n0), 64'd0);
      chk("ready_after_reset", 64'(cmd_ready), 64'd1);
      @(posedge clk);
      #1;
      push_cmd(2'b00, 8'd9, 8'd8, 36'h111_222_333);
      wait_idle(50);
      chk("plot_after_reset", 64'(n_we - n0), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
